// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared serial bus: grants one master at a time
// and routes the owner's serial line, RW and address-phase flags to the slaves.
`timescale 1ns/1ps

module bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [N_MASTERS-1:0]         i_m_req,
    input  logic [N_MASTERS-1:0]         i_m_util,
    input  logic [N_MASTERS-1:0]         i_m_done,
    input  logic [N_MASTERS-1:0]         i_m_rw,
    input  logic [N_MASTERS-1:0]         i_m_add,
    input  logic [N_MASTERS-1:0]         i_m_bus_out,
    output logic [N_MASTERS-1:0]         o_m_grant,
    output logic                         o_s_bus,
    output logic                         o_s_rw,
    output logic                         o_s_add,
    output logic                         o_bus_busy,
    output logic [$clog2(N_MASTERS)-1:0] o_owner
);

    localparam int PW = $clog2(N_MASTERS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]        TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]        TIMER_MAX  = {TW{1'b1}};
    localparam logic [PW-1:0]        OWNER_LAST = PW'(N_MASTERS - 1);
    localparam logic [N_MASTERS-1:0] GRANT_ONE  = {{(N_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_BUSY,
        ST_RELEASE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [N_MASTERS-1:0]  r_grant;
    logic                  r_bus_busy;
    logic [PW-1:0]         r_owner;
    logic [PW-1:0]         r_ptr;
    logic [TW-1:0]         r_timer;

    logic [N_MASTERS-1:0]  w_req_rot;
    logic                  w_found;
    int                    w_offset;
    int                    w_sum;
    logic [PW-1:0]         w_winner;
    logic [PW-1:0]         w_ptr_next;

    // Rotate requests so bit 0 is the master at ptr; lowest set bit wins.
    assign w_req_rot = N_MASTERS'({i_m_req, i_m_req} >> r_ptr);

    always_comb begin
        w_found  = 1'b0;
        w_offset = 0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_found  = 1'b1;
                w_offset = i;
            end
        end
        w_sum    = int'(r_ptr) + w_offset;
        w_winner = (w_sum >= N_MASTERS) ? PW'(w_sum - N_MASTERS) : PW'(w_sum);
    end

    assign w_ptr_next = (r_owner == OWNER_LAST) ? '0 : r_owner + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Only the owner's UTIL/REQ/DONE steer the machine; BUSY has no timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (i_m_util[r_owner]) begin
                    w_state_next = ST_BUSY;
                end else if (!i_m_req[r_owner]) begin
                    w_state_next = ST_RELEASE;
                end else if (r_timer == TIMER_LAST) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_BUSY: begin
                if (i_m_done[r_owner]) begin
                    w_state_next = ST_RELEASE;
                end else if (!i_m_req[r_owner] && !i_m_util[r_owner]) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant    <= '0;
            r_bus_busy <= 1'b0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_timer    <= '0;
        end else begin
            r_bus_busy <= (w_state_next == ST_GRANTED) || (w_state_next == ST_BUSY);
            if (r_state == ST_IDLE && w_found) begin
                r_owner <= w_winner;
                r_grant <= GRANT_ONE << w_winner;
                r_timer <= '0;
            end else if (w_state_next == ST_RELEASE) begin
                r_grant <= '0;
            end
            if (r_state == ST_GRANTED && w_state_next == ST_GRANTED && r_timer != TIMER_MAX) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == ST_RELEASE) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign o_m_grant  = r_grant;
    assign o_bus_busy = r_bus_busy;
    assign o_owner    = r_owner;
    assign o_s_bus    = r_bus_busy & i_m_bus_out[r_owner];
    assign o_s_rw     = r_bus_busy & i_m_rw[r_owner];
    assign o_s_add    = r_bus_busy & i_m_add[r_owner];

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with two masters and a short timeout:
// grant latency, rotation, handover gap, revocation, slave mux and async reset.
`timescale 1ns/1ps

module tb_bus_arbiter;

    logic       clk;
    logic       rstN;
    logic [1:0] mReq;
    logic [1:0] mUtil;
    logic [1:0] mDone;
    logic [1:0] mRw;
    logic [1:0] mAdd;
    logic [1:0] mBusOut;
    logic [1:0] mGrant;
    logic       sBus;
    logic       sRw;
    logic       sAdd;
    logic       busBusy;
    logic       owner;

    int testCount;
    int failCount;

    bus_arbiter #(
        .N_MASTERS (2),
        .TIMEOUT   (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_m_req     (mReq),
        .i_m_util    (mUtil),
        .i_m_done    (mDone),
        .i_m_rw      (mRw),
        .i_m_add     (mAdd),
        .i_m_bus_out (mBusOut),
        .o_m_grant   (mGrant),
        .o_s_bus     (sBus),
        .o_s_rw      (sRw),
        .o_s_add     (sAdd),
        .o_bus_busy  (busBusy),
        .o_owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] util,
                                 input logic [1:0] done, input logic [1:0] rw,
                                 input logic [1:0] add, input logic [1:0] busOut);
        mReq    = req;
        mUtil   = util;
        mDone   = done;
        mRw     = rw;
        mAdd    = add;
        mBusOut = busOut;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] expGrant,
                               input logic expBusy, input logic expOwner);
        testCount++;
        assert (mGrant === expGrant) else begin
            failCount++;
            $error("[TB] FAIL %s grant observed=%b expected=%b", tag, mGrant, expGrant);
        end
        testCount++;
        assert (busBusy === expBusy) else begin
            failCount++;
            $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busBusy, expBusy);
        end
        testCount++;
        assert (owner === expOwner) else begin
            failCount++;
            $error("[TB] FAIL %s owner observed=%b expected=%b", tag, owner, expOwner);
        end
    endtask

    task automatic checkSlave(input string tag, input logic [2:0] expSlave);
        testCount++;
        assert ({sBus, sRw, sAdd} === expSlave) else begin
            failCount++;
            $error("[TB] FAIL %s slave observed=%b expected=%b", tag, {sBus, sRw, sAdd}, expSlave);
        end
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rstN      = 1'b0;
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (2) @(negedge clk);
        checkOutput("reset", 2'b00, 1'b0, 1'b0);
        checkSlave("resetSlave", 3'b000);
        rstN = 1'b1;

        // Single request from master 0, then a full transaction.
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
        stepCycle();
        checkOutput("grant0", 2'b01, 1'b1, 1'b0);
        checkSlave("granted0Slave", 3'b111);
        applyStimulus(2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10);
        #1 checkSlave("owner0Mux", 3'b010);
        stepCycle();
        checkOutput("busy0", 2'b01, 1'b1, 1'b0);
        applyStimulus(2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10);
        stepCycle();
        checkOutput("nonOwnerDone", 2'b01, 1'b1, 1'b0);
        applyStimulus(2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11);
        stepCycle();
        checkOutput("release0", 2'b00, 1'b0, 1'b0);
        checkSlave("release0Slave", 3'b000);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        stepCycle();
        checkOutput("idleAfter0", 2'b00, 1'b0, 1'b0);

        // Both request; pointer now at 1 so master 1 wins.
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        stepCycle();
        checkOutput("ptrRotate", 2'b10, 1'b1, 1'b1);
        applyStimulus(2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01);
        #1 checkSlave("muxNonOwner", 3'b000);
        stepCycle();
        checkOutput("busy1", 2'b10, 1'b1, 1'b1);
        applyStimulus(2'b11, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10);
        #1 checkSlave("muxOwner", 3'b111);
        applyStimulus(2'b11, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01);
        #1 checkSlave("muxToggle", 3'b010);
        applyStimulus(2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11);
        stepCycle();
        checkOutput("release1", 2'b00, 1'b0, 1'b1);
        checkSlave("release1Slave", 3'b000);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11);
        stepCycle();
        checkOutput("gapIdle", 2'b00, 1'b0, 1'b1);
        checkSlave("idleSlave", 3'b000);
        stepCycle();
        checkOutput("rotateBack", 2'b01, 1'b1, 1'b0);

        // Master 0 withdraws its request while only granted.
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        stepCycle();
        checkOutput("withdraw", 2'b00, 1'b0, 1'b0);
        stepCycle();
        checkOutput("withdrawIdle", 2'b00, 1'b0, 1'b0);

        // Master 1 granted but never asserts UTIL: revoked after 4 cycles.
        stepCycle();
        checkOutput("toGrant", 2'b10, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("toHold", 2'b10, 1'b1, 1'b1);
        end
        stepCycle();
        checkOutput("toRevoke", 2'b00, 1'b0, 1'b1);
        stepCycle();
        checkOutput("toIdle", 2'b00, 1'b0, 1'b1);
        stepCycle();
        checkOutput("toRegrant", 2'b10, 1'b1, 1'b1);

        // Asynchronous reset while master 1 is mid-transaction.
        applyStimulus(2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        stepCycle();
        checkOutput("busyBeforeReset", 2'b10, 1'b1, 1'b1);
        #2 rstN = 1'b0;
        #1 checkOutput("asyncReset", 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        stepCycle();
        checkOutput("afterReset", 2'b01, 1'b1, 1'b0);

        // UTIL and DONE together in GRANTED: BUSY first, then release.
        applyStimulus(2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        stepCycle();
        checkOutput("doneUtilBusy", 2'b01, 1'b1, 1'b0);
        stepCycle();
        checkOutput("doneUtilRelease", 2'b00, 1'b0, 1'b0);

        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (2) stepCycle();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
